// File: rtl/host_dma_pkg.sv
// host_dma_pkg: shared types and constants for the host-memory read DMA.
//   t_cl_addr   cache-line address (byte address >> 6)
//   t_cl_data   one 64-byte cache line
//   t_dma_state reader FSM states
package host_dma_pkg;

  localparam int CL_BYTES   = 64;
  localparam int CL_DATA_W  = CL_BYTES * 8;
  localparam int MDATA_W    = 16;
  localparam int DEF_ADDR_W = 42;

  typedef logic [DEF_ADDR_W-1:0] t_cl_addr;
  typedef logic [CL_DATA_W-1:0]  t_cl_data;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } t_dma_state;

endpackage

// File: rtl/host_dma_rob.sv
// host_dma_rob: reorder buffer for out-of-order read responses.
//   clk, rst              clock, async active-high reset (valid bits only)
//   clr_all               drop every valid bit (new transfer)
//   wr_en/wr_idx/wr_data  response write port, sets the slot's valid bit
//   clr_en/clr_idx        head clear port, clears the slot's valid bit
//   rd_idx                slot the caller will present next cycle
//   rd_valid_nxt/rd_data_nxt  post-update view of slot rd_idx, so the caller
//                         can register it without an extra cycle of latency
module host_dma_rob
  import host_dma_pkg::*;
#(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_idx,
  input  t_cl_data         wr_data,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_idx,
  input  logic [TAG_W-1:0] rd_idx,
  output logic             rd_valid_nxt,
  output t_cl_data         rd_data_nxt
);

  localparam int DEPTH = 1 << TAG_W;

  t_cl_data         mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // Clear and set target different slots whenever both fire, so their order
  // here does not matter.
  always_comb begin
    vld_d = vld_q;
    if (clr_en) vld_d[clr_idx] = 1'b0;
    if (wr_en)  vld_d[wr_idx]  = 1'b1;
    if (clr_all) vld_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Line storage needs no reset: nothing reads a slot without its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_valid_nxt = vld_d[rd_idx];
  assign rd_data_nxt  = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem_q[rd_idx];

endmodule

// File: rtl/host_rd_dma.sv
// host_rd_dma: CCI-P c0 read initiator. Issues sequential cache-line reads,
// gathers out-of-order responses in a ROB and streams lines in address order.
//   start/base_addr/num_lines  transfer request (accepted only when idle)
//   busy/done                  transfer status, done is a one-cycle pulse
//   c0_tx_alm_full, c0_req_*   read request channel
//   c0_rsp_*                   read response channel (pre-qualified reads)
//   out_valid/out_data/out_ready  ordered line stream
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; responses are discarded
// ST_RUN  | issuing requests, collecting responses, draining in order
// ST_DONE | transfer finished; done pulse is (or is being) presented
module host_rd_dma
  import host_dma_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int ADDR_W = $bits(t_cl_addr),
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   num_lines,
  output logic               busy,
  output logic               done,
  input  logic               c0_tx_alm_full,
  output logic               c0_req_valid,
  output logic [ADDR_W-1:0]  c0_req_addr,
  output logic [MDATA_W-1:0] c0_req_mdata,
  input  logic               c0_rsp_valid,
  input  logic [MDATA_W-1:0] c0_rsp_mdata,
  input  t_cl_data           c0_rsp_data,
  output logic               out_valid,
  output t_cl_data           out_data,
  input  logic               out_ready
);

  localparam logic [CNT_W-1:0] ROB_DEPTH = CNT_W'(1 << TAG_W);

  t_dma_state         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [MDATA_W-1:0] req_mdata_q, req_mdata_d;
  logic               out_valid_q, out_valid_d;
  t_cl_data           out_data_q, out_data_d;

  logic               issue_ok;
  logic               drain_fire;
  logic               rob_clr_all;
  logic               rob_wr_en;
  logic               rob_rd_valid_nxt;
  t_cl_data           rob_rd_data_nxt;
  logic               unused_rsp_mdata;

  // Tag upper bits are always zero on our requests; only the slot is used.
  assign unused_rsp_mdata = ^c0_rsp_mdata[MDATA_W-1:TAG_W];

  assign drain_fire = out_valid_q & out_ready;
  assign issue_ok   = (state_q == ST_RUN) && (issue_cnt_q < num_q) && !c0_tx_alm_full &&
                      ((issue_cnt_q - drain_cnt_q) < ROB_DEPTH);
  assign rob_wr_en  = c0_rsp_valid && (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issue_cnt_d = issue_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    req_mdata_d = req_mdata_q;
    rob_clr_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          num_d       = num_lines;
          issue_cnt_d = '0;
          drain_cnt_d = '0;
          busy_d      = 1'b1;
          rob_clr_all = 1'b1;
          state_d     = (num_lines == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_ok) begin
          req_valid_d = 1'b1;
          req_addr_d  = base_q + ADDR_W'(issue_cnt_q);
          req_mdata_d = MDATA_W'(issue_cnt_q[TAG_W-1:0]);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (drain_fire) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          // Pulse done right after the last handshake.
          if (drain_cnt_d == num_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        // Arriving from RUN the pulse is already out; an empty transfer
        // raises it here instead.
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage looks at the head slot as it will be after this edge, which
  // keeps one drain per cycle with a registered out_valid/out_data.
  always_comb begin
    out_valid_d = (state_d == ST_RUN) && rob_rd_valid_nxt;
    out_data_d  = out_data_q;
    if (rob_rd_valid_nxt && !(out_valid_q && !out_ready)) out_data_d = rob_rd_data_nxt;
  end

  host_dma_rob #(.TAG_W(TAG_W)) u_rob (
    .clk          (clk),
    .rst          (rst),
    .clr_all      (rob_clr_all),
    .wr_en        (rob_wr_en),
    .wr_idx       (c0_rsp_mdata[TAG_W-1:0]),
    .wr_data      (c0_rsp_data),
    .clr_en       (drain_fire),
    .clr_idx      (drain_cnt_q[TAG_W-1:0]),
    .rd_idx       (drain_cnt_d[TAG_W-1:0]),
    .rd_valid_nxt (rob_rd_valid_nxt),
    .rd_data_nxt  (rob_rd_data_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issue_cnt_q <= issue_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign c0_req_valid = req_valid_q;
  assign c0_req_addr  = req_addr_q;
  assign c0_req_mdata = req_mdata_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_host_rd_dma.sv
// tb_host_rd_dma: scoreboard bench for host_rd_dma with a host-memory
// responder model returning reads in random order.
module tb_host_rd_dma;
  localparam int TAG_W  = 3;
  localparam int ADDR_W = 42;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [CNT_W-1:0]   num_lines;
  logic               busy, done;
  logic               c0_tx_alm_full;
  logic               c0_req_valid;
  logic [ADDR_W-1:0]  c0_req_addr;
  logic [15:0]        c0_req_mdata;
  logic               c0_rsp_valid;
  logic [15:0]        c0_rsp_mdata;
  logic [511:0]       c0_rsp_data;
  logic               out_valid;
  logic [511:0]       out_data;
  logic               out_ready;

  host_rd_dma #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .c0_tx_alm_full(c0_tx_alm_full),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard state
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [511:0]      exp_line_q[$];
  int                pool_tag[$];
  logic [ADDR_W-1:0] pool_addr[$];
  int                want_q[$];
  int  req_idx, drains, drn_h1, drn_h2;
  int  done_due = -1;
  int  start_cyc, first_ov_cyc, first_req_cyc, tag0_cyc;
  bit  done_seen, mon_en, prev_alm, hold_pend;
  logic [511:0] hold_data;
  int  rsp_mode, ready_mode;
  bit  inject_req;
  int  inject_tag;

  function automatic logic [511:0] line_of(input logic [ADDR_W-1:0] a);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = {6'(k), 16'hC0DE, a};
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: checks everything the DUT presents against the scoreboard
  always @(negedge clk) begin : mon
    logic [ADDR_W-1:0] ea;
    if (mon_en) begin
      if (prev_alm) chk("alm_gap", c0_req_valid, 1'b0);
      if (c0_req_valid) begin
        if (exp_addr_q.size() == 0) chk("spurious_req", 1'b1, 1'b0);
        else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", c0_req_addr, ea);
          chk("req_mdata", c0_req_mdata, 16'(req_idx % DEPTH));
          if (first_req_cyc < 0) first_req_cyc = cyc;
          req_idx++;
          if (req_idx - drn_h2 > DEPTH) chk("outstanding", 32'(req_idx - drn_h2), 32'(DEPTH));
          pool_tag.push_back(int'(c0_req_mdata[TAG_W-1:0]));
          pool_addr.push_back(ea);
        end
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hold_data);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_line_q.size() == 0) chk("spurious_out", 1'b1, 1'b0);
        else begin
          chk("out_data", out_data, exp_line_q.pop_front());
          drains++;
          if (exp_line_q.size() == 0 && exp_addr_q.size() == 0) done_due = cyc + 1;
        end
      end
      if (done || cyc == done_due) begin
        chk("done_pulse", done, cyc == done_due);
        if (done) begin
          done_seen = 1;
          chk("busy_at_done", busy, 1'b0);
        end
      end
      drn_h2 = drn_h1;
      drn_h1 = drains;
      prev_alm = c0_tx_alm_full;
    end
  end

  // host responder and consumer ready driver
  initial begin : host
    int pick;
    c0_rsp_valid = 0; c0_rsp_mdata = '0; c0_rsp_data = '0; out_ready = 0;
    forever begin
      @(posedge clk); #1;
      c0_rsp_valid = 0;
      out_ready = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (inject_req) begin
        c0_rsp_valid = 1; c0_rsp_mdata = 16'(inject_tag); c0_rsp_data = line_of('1);
        inject_req = 0;
      end else if (pool_tag.size() > 0) begin
        pick = -1;
        if (rsp_mode == 0) pick = 0;
        else if (rsp_mode == 1) begin
          if ($urandom_range(0, 9) < 6) pick = $urandom_range(0, pool_tag.size() - 1);
        end else if (want_q.size() > 0) begin
          for (int i = 0; i < pool_tag.size(); i++) if (pool_tag[i] == want_q[0]) pick = i;
        end
        if (pick >= 0) begin
          c0_rsp_valid = 1;
          c0_rsp_mdata = 16'(pool_tag[pick]);
          c0_rsp_data  = line_of(pool_addr[pick]);
          if (pool_tag[pick] == 0) tag0_cyc = cyc;
          if (rsp_mode == 2) void'(want_q.pop_front());
          pool_tag.delete(pick);
          pool_addr.delete(pick);
        end
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(b + ADDR_W'(i));
      exp_line_q.push_back(line_of(b + ADDR_W'(i)));
    end
    req_idx = 0; drains = 0; drn_h1 = 0; drn_h2 = 0;
    first_ov_cyc = -1; first_req_cyc = -1; done_seen = 0;
    start_cyc = cyc;
    if (n == 0) done_due = cyc + 2;
    base_addr = b; num_lines = CNT_W'(n); start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done_seen && n < budget) begin @(posedge clk); n++; end
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", name, budget);
    end
    #1;
    chk({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_line_left"}, 32'(exp_line_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    rst = 1; start = 0; base_addr = '0; num_lines = '0; c0_tx_alm_full = 0;
    rsp_mode = 0; ready_mode = 1; inject_req = 0; mon_en = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_valid", c0_req_valid, 1'b0);
    chk("rst_req_addr", c0_req_addr, '0);
    chk("rst_req_mdata", c0_req_mdata, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    mon_en = 1;

    // basic in-order
    do_start(42'h1000, 4);
    wait_done(100, "basic");
    chk("first_req_latency", 32'(first_req_cyc - start_cyc), 32'd2);

    // reorder 3,1,0,2
    want_q = '{3, 1, 0, 2};
    rsp_mode = 2;
    do_start(42'h2000, 4);
    wait_done(100, "reorder");
    chk("first_out_after_tag0", 32'(first_ov_cyc - tag0_cyc), 32'd1);
    rsp_mode = 0;

    // credit limit with consumer stalled
    ready_mode = 0;
    do_start(42'h3000, 20);
    repeat (40) @(posedge clk);
    #1;
    chk("credit_reqs", 32'(req_idx), 32'd8);
    chk("credit_head_valid", out_valid, 1'b1);
    ready_mode = 1;
    wait_done(300, "credit");

    // almost-full window
    do_start(42'h4000, 30);
    repeat (4) @(posedge clk);
    #1 c0_tx_alm_full = 1;
    repeat (10) @(posedge clk);
    #1 c0_tx_alm_full = 0;
    wait_done(300, "almfull");

    // empty transfer
    do_start(42'h5000, 0);
    wait_done(20, "zero");

    // address wrap
    do_start(42'h3FF_FFFF_FFFE, 3);
    wait_done(100, "wrap");

    // randomized transfers, random response order and backpressure
    rsp_mode = 1; ready_mode = 2;
    for (int t = 0; t < 4; t++) begin
      int n;
      logic [ADDR_W-1:0] b;
      n = (t == 1) ? 20 : $urandom_range(1, 24);
      b = ADDR_W'({$urandom, $urandom});
      do_start(b, n);
      if (t == 1) begin
        repeat (2) @(posedge clk);
        #1 base_addr = 42'h0; num_lines = 16'd5; start = 1;
        @(posedge clk); #1 start = 0;
        chk("start_busy_ignored", busy, 1'b1);
      end
      wait_done(n * 30 + 100, "random");
    end

    // reset mid-run
    rsp_mode = 0; ready_mode = 1;
    do_start(42'h6000, 10);
    begin
      int n = 0;
      while (drains < 5 && n < 200) begin @(posedge clk); n++; end
      chk("midrun_reached", 32'(drains >= 5), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1; mon_en = 0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    exp_addr_q.delete(); exp_line_q.delete(); pool_tag.delete(); pool_addr.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_busy", busy, 1'b0);
      chk("rst_hold_out_valid", out_valid, 1'b0);
    end
    rst = 0;
    pool_tag.delete(); pool_addr.delete();
    done_due = -1; hold_pend = 0; prev_alm = 0; drn_h1 = 0; drn_h2 = 0;
    @(posedge clk); #1;
    inject_tag = 1; inject_req = 1;
    mon_en = 1;
    repeat (4) begin
      @(negedge clk);
      chk("late_rsp_out_valid", out_valid, 1'b0);
    end
    do_start(42'h7000, 2);
    wait_done(100, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
